// File: rtl/allpass_tdm.sv
// Time-multiplexed multi-channel IIR allpass filter.
// One shared multiply-accumulate unit walks through 2*ORDER+1 product terms per sample.
// Each channel keeps its own x/y history.
module allpass_tdm #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned FRAC     = 14,
  parameter int unsigned ORDER    = 6,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH*ORDER-1:0] coef,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [CHW-1:0]         in_chan,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [CHW-1:0]         out_chan,
  output logic                   out_sat
);

  localparam int unsigned NTERM = 2 * ORDER + 1;
  localparam int unsigned CNTW  = $clog2(NTERM);
  localparam int unsigned AW    = 2 * WIDTH + $clog2(NTERM) + 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(NTERM - 1);
  localparam logic [CHW:0]    NCH  = (CHW + 1)'(CHANNELS);
  localparam logic signed [AW-1:0] MAXV = $signed({{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
  localparam logic signed [AW-1:0] MINV = $signed({{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});
  localparam logic signed [AW-1:0] HALF = $signed(AW'(1) << (FRAC - 1));

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                    state_q;
  logic                      in_ready_q, out_valid_q, out_sat_q;
  logic [WIDTH-1:0]          out_data_q;
  logic [CHW-1:0]            out_chan_q, ch_q;
  logic signed [WIDTH-1:0]   x_q;
  logic [WIDTH*ORDER-1:0]    coef_q;
  logic [CNTW-1:0]           cnt_q;
  logic signed [AW-1:0]      acc_q;
  logic signed [WIDTH-1:0]   x_hist_q [CHANNELS][ORDER];
  logic signed [WIDTH-1:0]   y_hist_q [CHANNELS][ORDER];

  logic signed [WIDTH-1:0]   a_arr  [ORDER];
  logic signed [WIDTH-1:0]   xh_sel [ORDER];
  logic signed [WIDTH-1:0]   yh_sel [ORDER];
  logic signed [WIDTH-1:0]   samp, cf;
  logic                      use_shift, use_neg;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [AW-1:0]      term, acc_d, rnd, shr;
  logic [WIDTH-1:0]          out_data_d;
  logic                      out_sat_d;
  logic                      chan_ok;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_sat   = out_sat_q;
  assign chan_ok   = ({1'b0, in_chan} < NCH);

  // Unpack latched coefficients (a_arr[j] holds a_{j+1}) and pick the active channel's history
  always_comb begin
    for (int j = 0; j < ORDER; j++) begin
      a_arr[j]  = coef_q[WIDTH*j +: WIDTH];
      xh_sel[j] = '0;
      yh_sel[j] = '0;
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_q == CHW'(c)) begin
        xh_sel = x_hist_q[c];
        yh_sel = y_hist_q[c];
      end
    end
  end

  // Operand selection for the current MAC step: x terms first, then the y feedback terms
  always_comb begin
    samp      = '0;
    cf        = '0;
    use_shift = 1'b0;
    use_neg   = 1'b0;
    if (cnt_q == '0) begin
      samp = x_q;
      cf   = a_arr[ORDER-1];
    end
    for (int k = 1; k < ORDER; k++) begin
      if (cnt_q == CNTW'(k)) begin
        samp = xh_sel[k-1];
        cf   = a_arr[ORDER-k-1];
      end
    end
    if (cnt_q == CNTW'(ORDER)) begin
      samp      = xh_sel[ORDER-1];
      use_shift = 1'b1;
    end
    for (int k = 1; k <= ORDER; k++) begin
      if (cnt_q == CNTW'(ORDER + k)) begin
        samp    = yh_sel[k-1];
        cf      = a_arr[k-1];
        use_neg = 1'b1;
      end
    end
  end

  // Product term, accumulation, then round-half-up and saturation of the final sum
  always_comb begin
    prod = (2*WIDTH)'(samp) * (2*WIDTH)'(cf);
    if (use_shift) term = AW'(samp) <<< FRAC;
    else           term = AW'(prod);
    if (use_neg) term = -term;
    acc_d = acc_q + term;
    rnd   = acc_d + HALF;
    shr   = rnd >>> FRAC;
    out_sat_d  = 1'b0;
    out_data_d = WIDTH'(shr);
    if (shr > MAXV) begin
      out_data_d = WIDTH'(MAXV);
      out_sat_d  = 1'b1;
    end else if (shr < MINV) begin
      out_data_d = WIDTH'(MINV);
      out_sat_d  = 1'b1;
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_sat_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      ch_q        <= '0;
      coef_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Out-of-range channels are accepted and silently dropped
          if (in_valid && in_ready_q && chan_ok) begin
            x_q        <= in_data;
            ch_q       <= in_chan;
            coef_q     <= coef;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (cnt_q == LAST) begin
            out_valid_q <= 1'b1;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_chan_q  <= ch_q;
            state_q     <= OUT;
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Per-channel history shift on the output handshake; the saturated y is what gets stored
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int j = 0; j < ORDER; j++) begin
          x_hist_q[c][j] <= '0;
          y_hist_q[c][j] <= '0;
        end
      end
    end else if (state_q == OUT && out_ready) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (ch_q == CHW'(c)) begin
          x_hist_q[c][0] <= x_q;
          y_hist_q[c][0] <= out_data_q;
          for (int j = 1; j < ORDER; j++) begin
            x_hist_q[c][j] <= x_hist_q[c][j-1];
            y_hist_q[c][j] <= y_hist_q[c][j-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_allpass_tdm.sv
// Directed bench for allpass_tdm: first-order 4-channel instance plus a second-order pure-delay instance.
module tb_allpass_tdm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // first-order, 4 channels, 3-bit channel index so out-of-range channels can be driven
  logic [15:0] coef;
  logic        in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [15:0] in_data, out_data;
  logic [2:0]  in_chan, out_chan;

  // second-order, single channel
  logic [31:0] coef2;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_sat2;
  logic [15:0] in_data2, out_data2;
  logic [0:0]  in_chan2, out_chan2;

  int total = 0;
  int bad   = 0;

  allpass_tdm #(.WIDTH(16), .FRAC(14), .ORDER(1), .CHANNELS(4), .CHW(3)) dut (
    .clk(clk), .rst(rst), .coef(coef),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chan(in_chan),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .out_sat(out_sat)
  );

  allpass_tdm #(.WIDTH(16), .FRAC(14), .ORDER(2), .CHANNELS(1)) dut2 (
    .clk(clk), .rst(rst), .coef(coef2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_chan(in_chan2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_chan(out_chan2), .out_sat(out_sat2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_valid2 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Push one sample into the chosen instance and collect its result; lat counts edges from acceptance
  task automatic xfer(input int which, input int chan, input int data,
                      output int y, output int sat, output int och, output int lat);
    int n;
    if (which == 0) begin
      in_valid = 1'b1; in_chan = 3'(chan); in_data = 16'(data); out_ready = 1'b1;
    end else begin
      in_valid2 = 1'b1; in_chan2 = 1'(chan); in_data2 = 16'(data); out_ready2 = 1'b1;
    end
    n = 0;
    while (((which == 0) ? !in_ready : !in_ready2) && n < 50) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    in_valid2 = 1'b0;
    lat = 1;
    while (((which == 0) ? !out_valid : !out_valid2) && lat < 60) begin
      tick();
      lat++;
    end
    y = 0; sat = 0; och = 0;
    if ((which == 0) ? !out_valid : !out_valid2) begin
      chk("out_valid_timeout", 0, 1);
    end else if (which == 0) begin
      y = int'($signed(out_data)); sat = int'(out_sat); och = int'(out_chan);
    end else begin
      y = int'($signed(out_data2)); sat = int'(out_sat2); och = int'(out_chan2);
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int y, sat, och, lat, seen;
    int fo [5];
    int pd [4];
    fo = '{8192, 12288, -6144, 3072, -1536};
    pd = '{0, 0, 16384, 0};

    rst = 1'b1;
    coef = '0; in_valid = 1'b0; in_data = '0; in_chan = '0; out_ready = 1'b1;
    coef2 = '0; in_valid2 = 1'b0; in_data2 = '0; in_chan2 = '0; out_ready2 = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_chan", int'(out_chan), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    rst = 1'b0;

    // pure delay: second order with all coefficients zero
    for (int i = 0; i < 4; i++) begin
      xfer(1, 0, (i == 0) ? 16384 : 0, y, sat, och, lat);
      chk($sformatf("delay_y%0d", i), y, pd[i]);
      chk($sformatf("delay_sat%0d", i), sat, 0);
      if (i == 0) chk("delay_latency", lat, 6);
    end

    // first-order impulse response on ch0
    coef = 16'd8192;
    for (int i = 0; i < 5; i++) begin
      xfer(0, 0, (i == 0) ? 16384 : 0, y, sat, och, lat);
      chk($sformatf("fo_y%0d", i), y, fo[i]);
      chk($sformatf("fo_sat%0d", i), sat, 0);
      chk($sformatf("fo_lat%0d", i), lat, 4);
    end

    // rounding at the half-LSB boundary on fresh channels
    do_reset();
    coef = 16'd1;
    xfer(0, 1, 8192, y, sat, och, lat);
    chk("round_up", y, 1);
    xfer(0, 3, 8191, y, sat, och, lat);
    chk("round_down", y, 0);

    // saturation, then a follow-up sample that depends on the stored (clamped) y
    do_reset();
    coef = 16'h8000;
    xfer(0, 0, 20000, y, sat, och, lat);
    chk("sat_y", y, -32768);
    chk("sat_flag", sat, 1);
    xfer(0, 0, -20000, y, sat, och, lat);
    chk("sat_hist_y", y, -5536);
    chk("sat_hist_flag", sat, 0);

    // interleaved channels
    do_reset();
    coef = 16'd8192;
    for (int i = 0; i < 4; i++) begin
      xfer(0, 2, (i == 0) ? 16384 : 0, y, sat, och, lat);
      chk($sformatf("il_ch2_y%0d", i), y, fo[i]);
      chk($sformatf("il_ch2_chan%0d", i), och, 2);
      xfer(0, 1, 0, y, sat, och, lat);
      chk($sformatf("il_ch1_y%0d", i), y, 0);
      chk($sformatf("il_ch1_chan%0d", i), och, 1);
    end

    // backpressure; also coefficient change after acceptance must not matter
    in_valid = 1'b1; in_chan = 3'd3; in_data = 16'd16384; out_ready = 1'b0;
    tick();
    coef = 16'd0;
    in_data = 16'd1000;
    seen = 0;
    while (!out_valid && seen < 20) begin
      tick();
      seen++;
    end
    chk("bp_valid_arrived", int'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_valid%0d", i), int'(out_valid), 1);
      chk($sformatf("bp_data%0d", i), int'($signed(out_data)), 8192);
      chk($sformatf("bp_ready%0d", i), int'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);
    coef = 16'd8192;

    // reset during MAC aborts the sample and clears all histories
    in_valid = 1'b1; in_chan = 3'd0; in_data = 16'd16384;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("rst_mac_no_output", seen, 0);
    xfer(0, 0, 16384, y, sat, och, lat);
    chk("rst_mac_y0", y, 8192);
    xfer(0, 0, 0, y, sat, och, lat);
    chk("rst_mac_y1", y, 12288);
    xfer(0, 3, 0, y, sat, och, lat);
    chk("rst_mac_ch3_cleared", y, 0);

    // out-of-range channel is swallowed without output or history change
    in_valid = 1'b1; in_chan = 3'd5; in_data = 16'd16384;
    tick();
    in_valid = 1'b0;
    chk("drop_ready", int'(in_ready), 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("drop_no_output", seen, 0);
    xfer(0, 1, 0, y, sat, och, lat);
    chk("drop_ch1_untouched", y, 0);
    chk("drop_ch1_chan", och, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/allpass_tdm.md
Name: allpass_tdm

Overview:
- Time-multiplexed, multi-channel IIR allpass filter of configurable order.
- Uses one serial multiply-accumulate unit shared by all channels; per-channel x/y history is held in internal arrays.
- Samples enter and leave through valid/ready handshakes tagged with a channel index.
- Output uses round-half-up and saturation; the coefficient set is shared by all channels and latched per sample.

Parameters:
- WIDTH, 16: sample and coefficient width, two's complement.
- FRAC, 14: fractional bits of the coefficients (1.0 = 2^FRAC).
- ORDER, 6: filter order M, at least 1.
- CHANNELS, 4: number of independent channels, at least 1.
- CHW, max(1, clog2(CHANNELS)): channel index width.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous reset, active-high.
- coef, input, WIDTH*ORDER: packed a_1..a_M; a_k sits in bits [WIDTH*k-1 : WIDTH*(k-1)].
- in_valid, input, 1: input sample valid.
- in_ready, output, 1: block can accept a sample.
- in_data, input, WIDTH: input sample x.
- in_chan, input, CHW: channel of the input sample.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, WIDTH: result y.
- out_chan, output, CHW: channel of the result.
- out_sat, output, 1: result was saturated.

Behaviour:
- Transfer function per channel, with a_0 = 2^FRAC implicit:
  y[n] = ( sum_{k=0..M} a_{M-k}·x[n-k] − sum_{k=1..M} a_k·y[n-k] ) / 2^FRAC.
  - The x[n-M] term uses a_0 as an exact shift.
- Accumulator width is 2*WIDTH + clog2(2M+1) + 1. The accumulator is never truncated before the final step.
- Final step:
  - add 2^(FRAC-1), then arithmetic right shift by FRAC (round half up);
  - clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1];
  - out_sat = 1 when the clamp changed the value.
- FSM states: IDLE, MAC, OUT.
  - IDLE: in_ready = 1. On in_valid && in_ready, latch in_data, in_chan and coef; clear the accumulator; go to MAC.
  - MAC: in_ready = 0. Exactly one product is accumulated per cycle, 2M+1 cycles in total, then go to OUT.
  - OUT: out_valid = 1; out_data, out_chan and out_sat are stable while out_valid && !out_ready. When out_valid && out_ready:
    - shift the channel's x history (x[n] enters) and y history (saturated y enters);
    - go to IDLE.
- Latency: acceptance in cycle 0 gives out_valid first high in cycle 2M+2.
  - in_ready returns in the cycle after the output handshake.
  - Maximum throughput is one sample per 2M+3 cycles.
- Coefficient changes after acceptance do not affect the sample in flight.
- Channels are fully independent. Only the addressed channel's history is read or updated.
- in_chan ≥ CHANNELS:
  - the sample is accepted and dropped;
  - no output is produced and no history changes;
  - the FSM returns to IDLE in the next cycle.
- Reset:
  - all histories are cleared to 0;
  - state is IDLE, in_ready = 1, out_valid = 0, out_data = 0, out_chan = 0, out_sat = 0.
  - Reset mid-MAC or mid-OUT aborts the sample with no output and no history update.
- While out_valid is high, in_valid is ignored; no input is accepted until the output handshake completes.

Test Plan:
- Pure delay: ORDER=2, coef all 0, ch0 impulse 16384 then zeros → out_data 0, 0, 16384, 0, each with out_sat=0; latency measured as 6 cycles.
- First-order response: ORDER=1, a1=8192, ch0 impulse 16384 then zeros → 8192, 12288, −6144, 3072, −1536.
- Rounding: ORDER=1, a1=1.
  - Input 8192 on a fresh channel → y=1.
  - Input 8191 on another fresh channel → y=0.
- Saturation: ORDER=1, a1=−32768, input 20000 → out_data=−32768, out_sat=1; the history stores −32768.
- Interleaving: CHANNELS=4, ORDER=1, a1=8192; impulse on ch2 alternated with zeros on ch1.
  - ch2 outputs match the first-order sequence.
  - ch1 outputs stay 0.
  - out_chan matches the input channel every time.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles → outputs stable and in_ready=0 throughout.
  - Assert rst during MAC → no out_valid; the next impulse reproduces the fresh-channel response.
  - in_chan=5 with CHANNELS=4 → no output.
